// File: rtl/step0_0.sv
// Stage-0 radix-2 front end of the 512-point, 16-lane FFT: buffers beats 0-15, emits x[n]+/-x[n+256] on beats 16-31.
// Optional gap detection with a sticky frame_err output is enabled by defining STEP0_0_FRAME_ERR_EN.
module step0_0 #(
    parameter int IN_W  = 9,
    parameter int LANES = 16,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   din_valid,
    input  logic signed [IN_W-1:0] din_i      [0:LANES-1],
    input  logic signed [IN_W-1:0] din_q      [0:LANES-1],
    output logic                   dout_valid,
    output logic signed [IN_W:0]   dout_add_r [0:LANES-1],
    output logic signed [IN_W:0]   dout_add_i [0:LANES-1],
    output logic signed [IN_W:0]   dout_sub_r [0:LANES-1],
    output logic signed [IN_W:0]   dout_sub_i [0:LANES-1]
`ifdef STEP0_0_FRAME_ERR_EN
    ,
    output logic                   frame_err
`endif
);

    localparam int AW = $clog2(DEPTH);

    // Top bit of the beat counter selects the butterfly half of the frame.
    logic [AW:0]   beat_cnt_reg;
    logic [AW-1:0] buf_addr;
    logic          wr_en;
    logic          bfly_en;

    assign buf_addr = beat_cnt_reg[AW-1:0];
    assign wr_en    = din_valid && !beat_cnt_reg[AW];
    assign bfly_en  = din_valid && beat_cnt_reg[AW];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            beat_cnt_reg <= '0;
            dout_valid   <= 1'b0;
`ifdef STEP0_0_FRAME_ERR_EN
            frame_err    <= 1'b0;
`endif
        end else begin
            dout_valid <= bfly_en;
            if (din_valid) begin
                beat_cnt_reg <= beat_cnt_reg + 1'b1;
            end
`ifdef STEP0_0_FRAME_ERR_EN
            // A gap inside a frame abandons it; the next valid beat restarts at beat 0.
            else if (beat_cnt_reg != '0) begin
                beat_cnt_reg <= '0;
                frame_err    <= 1'b1;
            end
`endif
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic signed [IN_W-1:0] mem_i [0:DEPTH-1];
        logic signed [IN_W-1:0] mem_q [0:DEPTH-1];
        logic signed [IN_W:0]   a_r, a_i, b_r, b_i;

        // Buffer holds the first half-frame only; contents need no reset.
        always_ff @(posedge clk) begin
            if (rstn && wr_en) begin
                mem_i[buf_addr] <= din_i[gi];
                mem_q[buf_addr] <= din_q[gi];
            end
        end

        assign a_r = {mem_i[buf_addr][IN_W-1], mem_i[buf_addr]};
        assign a_i = {mem_q[buf_addr][IN_W-1], mem_q[buf_addr]};
        assign b_r = {din_i[gi][IN_W-1], din_i[gi]};
        assign b_i = {din_q[gi][IN_W-1], din_q[gi]};

        always_ff @(posedge clk) begin
            if (!rstn) begin
                dout_add_r[gi] <= '0;
                dout_add_i[gi] <= '0;
                dout_sub_r[gi] <= '0;
                dout_sub_i[gi] <= '0;
            end else if (bfly_en) begin
                dout_add_r[gi] <= a_r + b_r;
                dout_add_i[gi] <= a_i + b_i;
                dout_sub_r[gi] <= a_r - b_r;
                dout_sub_i[gi] <= a_i - b_i;
            end
        end
    end

endmodule

// File: tb/tb_step0_0.sv
// Directed self-checking bench for step0_0: ramp, extremes, back-to-back frames, mid-frame reset and input gaps.
// Gap handling checks follow STEP0_0_FRAME_ERR_EN when it is defined.
module tb_step0_0;

    logic              clk;
    logic              rstn;
    logic              din_valid;
    logic signed [8:0] din_i      [0:15];
    logic signed [8:0] din_q      [0:15];
    logic              dout_valid;
    logic signed [9:0] dout_add_r [0:15];
    logic signed [9:0] dout_add_i [0:15];
    logic signed [9:0] dout_sub_r [0:15];
    logic signed [9:0] dout_sub_i [0:15];
`ifdef STEP0_0_FRAME_ERR_EN
    logic              frame_err;
`endif

    step0_0 dut (
        .clk        (clk),
        .rstn       (rstn),
        .din_valid  (din_valid),
        .din_i      (din_i),
        .din_q      (din_q),
        .dout_valid (dout_valid),
        .dout_add_r (dout_add_r),
        .dout_add_i (dout_add_i),
        .dout_sub_r (dout_sub_r),
        .dout_sub_i (dout_sub_i)
`ifdef STEP0_0_FRAME_ERR_EN
        ,
        .frame_err  (frame_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Frame stimulus and hand-derived expected butterfly results per output beat.
    logic signed [8:0] fi [0:31][0:15];
    logic signed [8:0] fq [0:31][0:15];
    int ea_r [0:15][0:15];
    int ea_i [0:15][0:15];
    int es_r [0:15][0:15];
    int es_i [0:15][0:15];

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beats(input int from, input int to);
        for (int b = from; b <= to; b++) begin
            din_valid = 1'b1;
            for (int k = 0; k < 16; k++) begin
                din_i[k] = fi[b][k];
                din_q[k] = fq[b][k];
            end
            tick();
            check($sformatf("valid beat%0d", b), int'(dout_valid), (b >= 16) ? 1 : 0);
            if (b >= 16) begin
                for (int k = 0; k < 16; k++) begin
                    check($sformatf("add_r b%0d k%0d", b, k), int'(dout_add_r[k]), ea_r[b-16][k]);
                    check($sformatf("add_i b%0d k%0d", b, k), int'(dout_add_i[k]), ea_i[b-16][k]);
                    check($sformatf("sub_r b%0d k%0d", b, k), int'(dout_sub_r[k]), es_r[b-16][k]);
                    check($sformatf("sub_i b%0d k%0d", b, k), int'(dout_sub_i[k]), es_i[b-16][k]);
                end
            end
        end
        din_valid = 1'b0;
    endtask

    task automatic idle(input int n, input string tag);
        din_valid = 1'b0;
        for (int c = 0; c < n; c++) begin
            tick();
            check($sformatf("%s idle%0d", tag, c), int'(dout_valid), 0);
        end
    endtask

    // Ramp: sample s truncated to 9 bits on I, bitwise inverse on Q.
    // n<256: I=n, Q=-1-n ; second half: I=n-256, Q=255-n.
    task automatic load_ramp();
        for (int b = 0; b < 32; b++) begin
            for (int k = 0; k < 16; k++) begin
                fi[b][k] = 9'(b * 16 + k);
                fq[b][k] = ~fi[b][k];
            end
        end
        for (int b = 0; b < 16; b++) begin
            for (int k = 0; k < 16; k++) begin
                ea_r[b][k] = 2 * (b * 16 + k) - 256;
                es_r[b][k] = 256;
                ea_i[b][k] = 254 - 2 * (b * 16 + k);
                es_i[b][k] = -256;
            end
        end
    endtask

    // Constant halves: I first=a, second=c ; Q first=c, second=a.
    task automatic load_const(input int a, input int c);
        for (int b = 0; b < 32; b++) begin
            for (int k = 0; k < 16; k++) begin
                fi[b][k] = (b < 16) ? 9'(a) : 9'(c);
                fq[b][k] = (b < 16) ? 9'(c) : 9'(a);
            end
        end
        for (int b = 0; b < 16; b++) begin
            for (int k = 0; k < 16; k++) begin
                ea_r[b][k] = a + c;
                es_r[b][k] = a - c;
                ea_i[b][k] = a + c;
                es_i[b][k] = c - a;
            end
        end
    endtask

    initial begin
        rstn      = 1'b0;
        din_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            din_i[k] = '0;
            din_q[k] = '0;
        end
        tick();
        tick();
        check("reset valid", int'(dout_valid), 0);
        check("reset add_r0", int'(dout_add_r[0]), 0);
        check("reset sub_i15", int'(dout_sub_i[15]), 0);
`ifdef STEP0_0_FRAME_ERR_EN
        check("reset frame_err", int'(frame_err), 0);
`endif
        rstn = 1'b1;

        // Ramp frame, contiguous.
        load_ramp();
        drive_beats(0, 31);
        idle(1, "post ramp");
        check("hold add_r", int'(dout_add_r[15]), ea_r[15][15]);
        check("hold sub_i", int'(dout_sub_i[15]), es_i[15][15]);

        // Extremes in both orders: no wrap in the 10-bit result.
        load_const(-256, 255);
        drive_beats(0, 31);
        load_const(255, -256);
        drive_beats(0, 31);
        idle(2, "post ext");

        // Three back-to-back frames with distinct constants.
        load_const(10, -20);
        drive_beats(0, 31);
        load_const(100, 7);
        drive_beats(0, 31);
        load_const(-128, 127);
        drive_beats(0, 31);
        idle(1, "post b2b");

        // Reset mid-frame at beat 20, with valid random data held during reset.
        load_ramp();
        drive_beats(0, 19);
        rstn = 1'b0;
        for (int c = 0; c < 2; c++) begin
            din_valid = 1'b1;
            for (int k = 0; k < 16; k++) begin
                din_i[k] = 9'($urandom);
                din_q[k] = 9'($urandom);
            end
            tick();
            check($sformatf("rst valid c%0d", c), int'(dout_valid), 0);
            check($sformatf("rst add_r3 c%0d", c), int'(dout_add_r[3]), 0);
            check($sformatf("rst sub_q9 c%0d", c), int'(dout_sub_i[9]), 0);
        end
        din_valid = 1'b0;
        rstn      = 1'b1;
        load_const(-256, 255);
        drive_beats(0, 31);

        // Three-cycle gap at beat 10.
        load_const(50, -3);
        drive_beats(0, 9);
        idle(3, "gap");
`ifdef STEP0_0_FRAME_ERR_EN
        check("gap frame_err", int'(frame_err), 1);
        load_const(-77, 60);
        drive_beats(0, 31);
        check("sticky frame_err", int'(frame_err), 1);
`else
        drive_beats(10, 31);
`endif
        idle(1, "end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
